i2c_codec_slave: RTL

I2C write-only target that receives the 3-byte codec configuration frame: device address + W, sub-address, data. It is the receiving end of the codec programming interface and is used as a synthesizable codec register-port model and loop-back checker for the programming sequencer. It oversamples SCL/SDA on a fast system clock, ACKs matching bytes by pulling SDA low, and presents each received sub-address/data pair with a one-cycle valid strobe.

---
 rtl/i2c_codec_slave.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2c_codec_slave.sv
// Write-only I2C target for the 3-byte codec configuration frame (address+W, sub-address, data).
// SCL/SDA are oversampled on clk; matching bytes are ACKed and each completed pair is strobed out.
module i2c_codec_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_subaddr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // SDA runs one stage behind SCL so a data change at an SCL fall is seen after the fall.
    logic [SYNC_STAGES:0]   scl_pipe;
    logic [SYNC_STAGES+1:0] sda_pipe;

    logic scl_c, scl_d, sda_c, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic       byte_done, byte_done_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] sub_shadow, sub_next;
    logic [7:0] data_shadow, data_next;
    logic [7:0] wr_subaddr_next, wr_data_next;
    logic       wr_valid_next, frame_err_next, sda_oe_next;

    assign scl_c = scl_pipe[SYNC_STAGES-1];
    assign scl_d = scl_pipe[SYNC_STAGES];
    assign sda_c = sda_pipe[SYNC_STAGES];
    assign sda_d = sda_pipe[SYNC_STAGES+1];

    assign scl_rise  = scl_c & ~scl_d;
    assign scl_fall  = ~scl_c & scl_d;
    assign start_det = scl_c & sda_d & ~sda_c;
    assign stop_det  = scl_c & ~sda_d & sda_c;

    assign busy = (state != IDLE);

    // Pipelines reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-1:0], scl_in};
            sda_pipe <= {sda_pipe[SYNC_STAGES:0], sda_in};
        end
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            byte_done   <= 1'b0;
            shift_reg   <= 8'h00;
            sub_shadow  <= 8'h00;
            data_shadow <= 8'h00;
            wr_subaddr  <= 8'h00;
            wr_data     <= 8'h00;
            wr_valid    <= 1'b0;
            frame_err   <= 1'b0;
            sda_oe      <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            byte_done   <= byte_done_next;
            shift_reg   <= shift_next;
            sub_shadow  <= sub_next;
            data_shadow <= data_next;
            wr_subaddr  <= wr_subaddr_next;
            wr_data     <= wr_data_next;
            wr_valid    <= wr_valid_next;
            frame_err   <= frame_err_next;
            sda_oe      <= sda_oe_next;
        end
    end

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        byte_done_next  = byte_done;
        shift_next      = shift_reg;
        sub_next        = sub_shadow;
        data_next       = data_shadow;
        wr_subaddr_next = wr_subaddr;
        wr_data_next    = wr_data;
        wr_valid_next   = 1'b0;
        frame_err_next  = frame_err;

        if (start_det) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            shift_next     = 8'h00;
            sub_next       = 8'h00;
            data_next      = 8'h00;
            frame_err_next = 1'b0;
        end else if (stop_det) begin
            state_next     = IDLE;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            if (state != IDLE && state != IGNORE) begin
                frame_err_next = 1'b1;
            end
        end else begin
            case (state)
                ADDR, SUB, DATA: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda_c};
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        // The fall after the eighth bit opens the ACK slot.
                        byte_done_next = 1'b0;
                        if (state == ADDR) begin
                            if (shift_reg == {DEV_ADDR, 1'b0}) begin
                                state_next = ADDR_ACK;
                            end else begin
                                state_next     = IGNORE;
                                frame_err_next = 1'b1;
                            end
                        end else if (state == SUB) begin
                            sub_next   = shift_reg;
                            state_next = SUB_ACK;
                        end else begin
                            data_next  = shift_reg;
                            state_next = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) state_next = SUB;
                SUB_ACK:  if (scl_fall) state_next = DATA;
                DATA_ACK: begin
                    if (scl_fall) begin
                        state_next      = IGNORE;
                        wr_subaddr_next = sub_shadow;
                        wr_data_next    = data_shadow;
                        wr_valid_next   = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        sda_oe_next = (state_next == ADDR_ACK) || (state_next == SUB_ACK) ||
                      (state_next == DATA_ACK);
    end

endmodule
